// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: fetch, data, ALU and status signals of the ALU sequencer
//   master : the sequencer (drives requests, addresses, ALU operands, pc_out, retire)
//   slave  : memories / ALU / observer (drives acks, read data, ALU result)
interface alu_sequencer_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_byte;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic [15:0] pc_out;
    logic        retire;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_byte, dmem_addr, dmem_wdata,
        output alu_a, alu_b, alu_op, pc_out, retire,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata, alu_result, alu_zero
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_byte, dmem_addr, dmem_wdata,
        input  alu_a, alu_b, alu_op, pc_out, retire,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata, alu_result, alu_zero
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving an external ALU
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : instruction/data req-ack ports, ALU operands/result, pc_out, retire pulse
module alu_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input logic             clk,
    input logic             rst,
    alu_sequencer_if.master bus
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

    state_t      state, state_d;
    logic [15:0] pc, ir, res, mdata;
    logic [15:0] regs [16];
    logic [3:0]  op;
    logic        is_br, is_ld, is_st, is_mem, is_jmp, taken, mem_done;
    logic [15:0] imm4, off8, wb_data, wb_pc;

    function automatic logic [15:0] rd_reg(input logic [3:0] i);
        return i == 4'd0 ? 16'h0000 : regs[i];
    endfunction

    assign op       = ir[15:12];
    assign is_br    = op == 4'h2 || op == 4'h3;
    assign is_ld    = op == 4'h4 || op == 4'h5;
    assign is_st    = op == 4'h6 || op == 4'h7;
    assign is_mem   = is_ld || is_st;
    assign is_jmp   = op == 4'h0 || op == 4'h1;
    assign imm4     = {{12{ir[3]}}, ir[3:0]};
    assign off8     = {{8{ir[7]}}, ir[7:0]};
    // BLE: the ALU returns nonzero when a<=b, so "taken" is the inverse of zero
    assign taken    = op == 4'h2 ? bus.alu_zero : !bus.alu_zero;
    assign mem_done = bus.dmem_req && bus.dmem_ack;
    assign wb_data  = is_jmp ? pc + 16'd1 :
                      op == 4'h4 ? {{8{mdata[7]}}, mdata[7:0]} :
                      op == 4'h5 ? mdata : res;
    // JALR target uses the operands still held from DECODE (rs1 value, immediate)
    assign wb_pc    = op == 4'h0 ? pc + off8 :
                      op == 4'h1 ? bus.alu_a + bus.alu_b : pc + 16'd1;
    assign bus.imem_addr = pc;
    assign bus.pc_out    = pc;

    always_comb begin
        state_d    = state;
        bus.retire = 1'b0;
        case (state)
            FETCH:   state_d = (bus.imem_req && bus.imem_ack) ? DECODE : FETCH;
            DECODE:  state_d = EXEC;
            EXEC: begin
                state_d    = is_mem ? MEM : is_br ? FETCH : WB;
                bus.retire = is_br;
            end
            MEM: begin
                state_d    = mem_done ? (is_st ? FETCH : WB) : MEM;
                bus.retire = mem_done && is_st;
            end
            WB: begin
                state_d    = FETCH;
                bus.retire = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_d;
    end

    // Requests are registered from the next state, so they rise on entry to a
    // wait state and drop the cycle after the acknowledging edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc             <= RESET_PC;
            ir             <= '0;
            res            <= '0;
            mdata          <= '0;
            bus.imem_req   <= 1'b0;
            bus.dmem_req   <= 1'b0;
            bus.dmem_we    <= 1'b0;
            bus.dmem_byte  <= 1'b0;
            bus.dmem_addr  <= '0;
            bus.dmem_wdata <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_op     <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            bus.imem_req  <= state_d == FETCH;
            bus.dmem_req  <= state_d == MEM;
            bus.dmem_we   <= state_d == MEM && is_st;
            bus.dmem_byte <= state_d == MEM && (op == 4'h4 || op == 4'h6);
            if (state == FETCH && bus.imem_req && bus.imem_ack) ir <= bus.imem_rdata;
            if (state == DECODE) begin
                bus.alu_op <= op;
                bus.alu_a  <= rd_reg(is_br ? ir[11:8] : ir[7:4]);
                bus.alu_b  <= is_br ? rd_reg(ir[7:4]) : op[3:2] == 2'b10 ? rd_reg(ir[3:0]) : imm4;
            end
            if (state == EXEC) begin
                res <= bus.alu_result;
                if (is_br) pc <= taken ? pc + imm4 : pc + 16'd1;
                if (is_mem) begin
                    bus.dmem_addr  <= bus.alu_result;
                    bus.dmem_wdata <= rd_reg(ir[11:8]);
                end
            end
            if (state == MEM && mem_done) begin
                mdata <= bus.dmem_rdata;
                if (is_st) pc <= pc + 16'd1;
            end
            if (state == WB) begin
                if (ir[11:8] != 4'd0) regs[ir[11:8]] <= wb_data;
                pc <= wb_pc;
            end
        end
    end
endmodule
